// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: vsync/href edge detection, RGB565 byte-pair assembly,
// window crop with power-of-two decimation, and two-pixel packing onto the VRAM write port.
//
// state    | meaning
// IDLE     | not capturing; waits for cap_req
// WAIT_VS  | armed; waits for the vsync falling edge (frame start)
// ACTIVE   | capturing pixels of the current frame
// DONE     | one cycle; pulses cap_done, bumps frame_cnt, picks next state
module cam_capture_ctrl #(
    parameter int OUT_W     = 128,
    parameter int OUT_H     = 96,
    parameter int DEC_SHIFT = 2,
    parameter int X_OFS     = 64,
    parameter int Y_OFS     = 48,
    parameter int ADDR_W    = 13
) (
    input  logic              pclk,
    input  logic              rstb,
    input  logic              c_vsync,
    input  logic              href,
    input  logic [7:0]        in_data,
    input  logic              cap_mode,
    input  logic              cap_req,
    input  logic              cap_stop,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [31:0]       dina,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_short,
    output logic [7:0]        frame_cnt
);

    // 11-bit counters cover 1023 pixels/lines with headroom; they saturate at all-ones
    localparam int CW = 11;
    localparam logic [CW-1:0]     X_LO      = CW'(X_OFS);
    localparam logic [CW-1:0]     X_HI      = CW'(X_OFS + (OUT_W << DEC_SHIFT));
    localparam logic [CW-1:0]     Y_LO      = CW'(Y_OFS);
    localparam logic [CW-1:0]     Y_HI      = CW'(Y_OFS + (OUT_H << DEC_SHIFT));
    localparam logic [CW-1:0]     DEC_MASK  = CW'((1 << DEC_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] HALF_W    = ADDR_W'(OUT_W / 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H / 2 - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_ACTIVE  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              vs_q, href_q;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [15:0]       hold_q, hold_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [31:0]       dina_q, dina_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic [7:0]        fcnt_q, fcnt_d;

    logic              frame_start, vs_rise, line_end;
    logic [15:0]       pix;
    logic [CW-1:0]     dx, dy, ox, oy;
    logic              keep, write_word, last_write;
    logic [ADDR_W-1:0] word_addr;

    assign frame_start = vs_q & ~c_vsync;
    assign vs_rise     = c_vsync & ~vs_q;
    assign line_end    = href_q & ~href;
    assign pix         = {hi_q, in_data};

    assign dx = x_q - X_LO;
    assign dy = y_q - Y_LO;
    assign ox = dx >> DEC_SHIFT;
    assign oy = dy >> DEC_SHIFT;

    assign keep = (state_q == S_ACTIVE) && href && phase_q
               && (x_q >= X_LO) && (x_q < X_HI)
               && (y_q >= Y_LO) && (y_q < Y_HI)
               && ((dx & DEC_MASK) == '0) && ((dy & DEC_MASK) == '0);

    assign word_addr  = ADDR_W'(oy) * HALF_W + ADDR_W'(ox >> 1);
    assign write_word = keep & ox[0];
    assign last_write = write_word && (word_addr == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        hold_d  = hold_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        done_d  = 1'b0;
        short_d = short_q;
        fcnt_d  = fcnt_q;

        case (state_q)
            S_IDLE: begin
                if (cap_req) begin
                    state_d = S_WAIT_VS;
                    short_d = 1'b0;
                end
            end
            S_WAIT_VS: begin
                if (frame_start) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    addra_d = '0;
                end
            end
            S_ACTIVE: begin
                if (href) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = in_data;
                    end else if (x_q != '1) begin
                        x_d = x_q + 1'b1;
                    end
                end else if (line_end) begin
                    // a dangling high byte is dropped by resetting the phase
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (y_q != '1) begin
                        y_d = y_q + 1'b1;
                    end
                end
                if (keep && !ox[0]) begin
                    hold_d = pix;
                end
                if (write_word) begin
                    wea_d   = 1'b1;
                    addra_d = word_addr;
                    dina_d  = {pix, hold_q};
                end
                if (last_write) begin
                    state_d = S_DONE;
                end else if (vs_rise) begin
                    state_d = S_DONE;
                    short_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
                state_d = (cap_mode && !cap_stop) ? S_WAIT_VS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            vs_q    <= 1'b0;
            href_q  <= 1'b0;
            phase_q <= 1'b0;
            hi_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hold_q  <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= c_vsync;
            href_q  <= href;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hold_q  <= hold_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            done_q  <= done_d;
            short_q <= short_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign cap_busy  = (state_q != S_IDLE);
    assign cap_done  = done_q;
    assign cap_short = short_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: a reduced-geometry instance for full frames and a
// default-geometry instance for one partial frame, both checked against a pixel-level model.
module tb_cam_capture_ctrl;

    localparam int SW = 8, SH = 6, SD = 1, SXO = 3, SYO = 2, SAW = 5;

    logic pclk = 1'b0, rstb = 1'b0, c_vsync = 1'b0, href = 1'b0;
    logic [7:0] in_data = '0;
    logic cap_mode = 1'b0, cap_req = 1'b0, cap_stop = 1'b0, cap_req_d = 1'b0;

    logic           wea_s, cap_busy_s, cap_done_s, cap_short_s;
    logic [SAW-1:0] addra_s;
    logic [31:0]    dina_s;
    logic [7:0]     frame_cnt_s;
    logic           wea_d, cap_busy_d, cap_done_d, cap_short_d;
    logic [12:0]    addra_d;
    logic [31:0]    dina_d;
    logic [7:0]     frame_cnt_d;

    always #5 pclk = ~pclk;

    cam_capture_ctrl #(.OUT_W(SW), .OUT_H(SH), .DEC_SHIFT(SD), .X_OFS(SXO), .Y_OFS(SYO), .ADDR_W(SAW)) dut_s (
        .pclk(pclk), .rstb(rstb), .c_vsync(c_vsync), .href(href), .in_data(in_data),
        .cap_mode(cap_mode), .cap_req(cap_req), .cap_stop(cap_stop),
        .wea(wea_s), .addra(addra_s), .dina(dina_s), .cap_busy(cap_busy_s),
        .cap_done(cap_done_s), .cap_short(cap_short_s), .frame_cnt(frame_cnt_s));

    cam_capture_ctrl dut_d (
        .pclk(pclk), .rstb(rstb), .c_vsync(c_vsync), .href(href), .in_data(in_data),
        .cap_mode(cap_mode), .cap_req(cap_req_d), .cap_stop(cap_stop),
        .wea(wea_d), .addra(addra_d), .dina(dina_d), .cap_busy(cap_busy_d),
        .cap_done(cap_done_d), .cap_short(cap_short_d), .frame_cnt(frame_cnt_d));

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { int nlines; int nbytes; int exp_writes; int exp_last; logic exp_short; } vec_t;

    wr_t got_s[$], got_d[$], exp_s[$], exp_d[$];
    int  done_s = 0, done_d = 0;
    int  checks = 0, errors = 0;
    int  exp_fc = 0;
    int  m_full[2];

    always @(negedge pclk) begin
        if (wea_s) got_s.push_back('{addr: int'(addra_s), data: dina_s});
        if (wea_d) got_d.push_back('{addr: int'(addra_d), data: dina_d});
        if (cap_done_s) done_s = done_s + 1;
        if (cap_done_d) done_d = done_d + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pv(input int x, input int y, input int seed);
        return 16'(x + y * 640 + seed);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic vs_pulse();
        @(negedge pclk); c_vsync = 1'b1;
        repeat (2) @(negedge pclk);
        @(negedge pclk); c_vsync = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic pulse_req(input int inst);
        @(negedge pclk);
        if (inst == 0) cap_req = 1'b1; else cap_req_d = 1'b1;
        @(negedge pclk);
        cap_req = 1'b0; cap_req_d = 1'b0;
    endtask

    task automatic send_line(input int y, input int nbytes, input int seed);
        logic [15:0] p;
        for (int b = 0; b < nbytes; b++) begin
            p = pv(b / 2, y, seed);
            @(negedge pclk);
            href = 1'b1;
            in_data = (b % 2 == 0) ? p[15:8] : p[7:0];
        end
        @(negedge pclk); href = 1'b0; in_data = '0;
        repeat (2) @(negedge pclk);
    endtask

    // expected writes from the window/decimation/packing rules, stopping at the last word
    task automatic model_line(input int inst, input int y, input int nbytes, input int seed);
        int xo, yo, w, h, s, last, ox, oy;
        wr_t e;
        if (inst == 0) begin xo = SXO; yo = SYO; w = SW; h = SH; s = 1 << SD; end
        else begin xo = 64; yo = 48; w = 128; h = 96; s = 4; end
        last = w * h / 2 - 1;
        for (int x = 0; x < nbytes / 2; x++) begin
            if (m_full[inst] != 0) return;
            if (x >= xo && x < xo + w * s && y >= yo && y < yo + h * s
                && (x - xo) % s == 0 && (y - yo) % s == 0) begin
                ox = (x - xo) / s;
                oy = (y - yo) / s;
                if (ox % 2 == 1) begin
                    e.addr = oy * (w / 2) + ox / 2;
                    e.data = {pv(x, y, seed), pv(x - s, y, seed)};
                    if (inst == 0) exp_s.push_back(e); else exp_d.push_back(e);
                    if (e.addr == last) m_full[inst] = 1;
                end
            end
        end
    endtask

    task automatic wait_idle(input int inst, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!(inst == 0 ? cap_busy_s : cap_busy_d)) break;
            @(negedge pclk);
        end
        chk("idle_reached", 64'(inst == 0 ? cap_busy_s : cap_busy_d), 64'd0);
        repeat (3) @(negedge pclk);
    endtask

    task automatic compare_writes(input int inst, input int gb, input int eb);
        int ng, ne;
        wr_t g, e;
        ng = (inst == 0 ? got_s.size() : got_d.size()) - gb;
        ne = (inst == 0 ? exp_s.size() : exp_d.size()) - eb;
        chk("write_count_vs_model", 64'(ng), 64'(ne));
        for (int i = 0; i < ng && i < ne; i++) begin
            if (inst == 0) begin g = got_s[gb + i]; e = exp_s[eb + i]; end
            else begin g = got_d[gb + i]; e = exp_d[eb + i]; end
            chk($sformatf("write[%0d] addr_data", i), {32'(g.addr), g.data}, {32'(e.addr), e.data});
        end
    endtask

    task automatic run_single(input int nlines, input int nbytes, input int seed,
                              output int ng, output int last_addr);
        int gb, eb, d0;
        gb = got_s.size(); eb = exp_s.size(); d0 = done_s;
        cap_mode = 1'b0;
        pulse_req(0);
        vs_pulse();
        m_full[0] = 0;
        for (int y = 0; y < nlines; y++) begin
            send_line(y, nbytes, seed);
            model_line(0, y, nbytes, seed);
        end
        vs_pulse();
        wait_idle(0, 60);
        exp_fc++;
        compare_writes(0, gb, eb);
        chk("done_pulses", 64'(done_s - d0), 64'd1);
        chk("frame_cnt", 64'(frame_cnt_s), 64'(8'(exp_fc)));
        chk("cap_short", 64'(cap_short_s), 64'(m_full[0] == 0));
        if (exp_s.size() > eb) begin
            chk("addra_hold", 64'(addra_s), 64'(exp_s[$].addr));
            chk("dina_hold", 64'(dina_s), 64'(exp_s[$].data));
        end
        ng = got_s.size() - gb;
        last_addr = (ng > 0) ? got_s[$].addr : -1;
    endtask

    initial begin
        vec_t vt[7];
        int ng, last, gb, eb, d0, g4, any_short, hit, nl, nb, sd;
        logic [15:0] p;

        vt[0] = '{16, 44, 24, 23, 1'b0};   // full frame, wide lines
        vt[1] = '{8,  44, 12, 11, 1'b1};   // vsync after line 7
        vt[2] = '{16, 24, 12, 21, 1'b1};   // lines narrower than window
        vt[3] = '{16, 37, 24, 23, 1'b0};   // odd byte count per line
        vt[4] = '{13, 38, 24, 23, 1'b0};   // just enough pixels and lines
        vt[5] = '{13, 34, 18, 22, 1'b1};   // one pixel short of the last column
        vt[6] = '{12, 44, 20, 19, 1'b1};   // one line short of the last row
        m_full[0] = 0; m_full[1] = 0;

        repeat (3) @(negedge pclk);
        chk("rst_wea", 64'(wea_s), 64'd0);
        chk("rst_addra", 64'(addra_s), 64'd0);
        chk("rst_dina", 64'(dina_s), 64'd0);
        chk("rst_busy", 64'(cap_busy_s), 64'd0);
        chk("rst_done", 64'(cap_done_s), 64'd0);
        chk("rst_short", 64'(cap_short_s), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt_s), 64'd0);
        chk("rst_busy_default", 64'(cap_busy_d), 64'd0);
        @(negedge pclk); rstb = 1'b1;
        repeat (2) @(negedge pclk);

        for (int i = 0; i < 7; i++) begin
            run_single(vt[i].nlines, vt[i].nbytes, 17 * i + 5, ng, last);
            chk($sformatf("vec%0d writes", i), 64'(ng), 64'(vt[i].exp_writes));
            chk($sformatf("vec%0d last_addr", i), 64'(last), 64'(vt[i].exp_last));
            chk($sformatf("vec%0d short", i), 64'(cap_short_s), 64'(vt[i].exp_short));
        end

        for (int i = 0; i < 4; i++) begin
            nl = $urandom_range(16, 8); nb = $urandom_range(46, 20); sd = $urandom_range(60000, 0);
            run_single(nl, nb, sd, ng, last);
        end

        // continuous: three random frames, stop raised inside the third, fourth must be ignored
        gb = got_s.size(); eb = exp_s.size(); d0 = done_s; any_short = 0;
        cap_mode = 1'b1;
        pulse_req(0);
        for (int f = 0; f < 3; f++) begin
            nl = $urandom_range(16, 8); nb = $urandom_range(46, 20); sd = $urandom_range(60000, 0);
            vs_pulse();
            if (f == 2) cap_stop = 1'b1;
            m_full[0] = 0;
            for (int y = 0; y < nl; y++) begin
                send_line(y, nb, sd);
                model_line(0, y, nb, sd);
            end
            if (m_full[0] == 0) any_short = 1;
        end
        vs_pulse();
        g4 = got_s.size();
        for (int y = 0; y < 16; y++) send_line(y, 44, 99);
        vs_pulse();
        wait_idle(0, 60);
        exp_fc += 3;
        compare_writes(0, gb, eb);
        chk("cont_no_writes_frame4", 64'(got_s.size() - g4), 64'd0);
        chk("cont_done_pulses", 64'(done_s - d0), 64'd3);
        chk("cont_frame_cnt", 64'(frame_cnt_s), 64'(8'(exp_fc)));
        chk("cont_short", 64'(cap_short_s), 64'(any_short));
        cap_stop = 1'b0; cap_mode = 1'b0;

        // cap_req mid-frame while idle, then a second cap_req during ACTIVE
        gb = got_s.size(); eb = exp_s.size(); d0 = done_s;
        vs_pulse();
        for (int y = 0; y < 5; y++) send_line(y, 44, 3);
        pulse_req(0);
        chk("midreq_busy", 64'(cap_busy_s), 64'd1);
        for (int y = 5; y < 16; y++) send_line(y, 44, 3);
        chk("midreq_no_writes_before_vs", 64'(got_s.size() - gb), 64'd0);
        vs_pulse();
        m_full[0] = 0;
        for (int y = 0; y < 16; y++) begin
            if (y == 6) pulse_req(0);
            send_line(y, 44, 21);
            model_line(0, y, 44, 21);
        end
        vs_pulse();
        wait_idle(0, 60);
        exp_fc++;
        compare_writes(0, gb, eb);
        chk("midreq_writes", 64'(got_s.size() - gb), 64'd24);
        chk("midreq_done", 64'(done_s - d0), 64'd1);
        chk("midreq_fcnt", 64'(frame_cnt_s), 64'(8'(exp_fc)));

        // asynchronous reset at the first write of a kept line
        cap_mode = 1'b0;
        pulse_req(0);
        vs_pulse();
        for (int y = 0; y < 6; y++) send_line(y, 44, 8);
        hit = 0;
        for (int b = 0; b < 44 && hit == 0; b++) begin
            @(negedge pclk);
            if (wea_s) begin
                chk("pre_rst_busy", 64'(cap_busy_s), 64'd1);
                chk("pre_rst_fcnt_nonzero", 64'(frame_cnt_s != 8'd0), 64'd1);
                rstb = 1'b0;
                #1;
                chk("async_rst_wea", 64'(wea_s), 64'd0);
                chk("async_rst_busy", 64'(cap_busy_s), 64'd0);
                chk("async_rst_fcnt", 64'(frame_cnt_s), 64'd0);
                chk("async_rst_addra", 64'(addra_s), 64'd0);
                hit = 1;
            end else begin
                p = pv(b / 2, 6, 8);
                href = 1'b1;
                in_data = (b % 2 == 0) ? p[15:8] : p[7:0];
            end
        end
        chk("rst_write_seen", 64'(hit), 64'd1);
        @(negedge pclk); rstb = 1'b1; href = 1'b0; in_data = '0;
        gb = got_s.size();
        for (int y = 7; y < 16; y++) send_line(y, 44, 8);
        vs_pulse();
        chk("post_rst_no_writes", 64'(got_s.size() - gb), 64'd0);
        chk("post_rst_idle", 64'(cap_busy_s), 64'd0);
        exp_fc = 0;
        gb = got_s.size();
        run_single(16, 44, 40, ng, last);
        chk("restart_writes", 64'(ng), 64'd24);
        if (ng > 0) chk("restart_first_addr", 64'(got_s[gb].addr), 64'd0);

        // default geometry, partial frame: long lines only at y=48 and y=52
        chk("default_idle_no_writes", 64'(got_d.size()), 64'd0);
        gb = got_d.size(); eb = exp_d.size(); d0 = done_d;
        pulse_req(1);
        vs_pulse();
        m_full[1] = 0;
        for (int y = 0; y <= 52; y++) begin
            nb = (y == 48 || y == 52) ? 1160 : 8;
            send_line(y, nb, 0);
            model_line(1, y, nb, 0);
        end
        vs_pulse();
        wait_idle(1, 60);
        compare_writes(1, gb, eb);
        chk("dflt_writes", 64'(got_d.size() - gb), 64'd128);
        if (got_d.size() > gb) begin
            chk("dflt_word0_addr", 64'(got_d[gb].addr), 64'd0);
            chk("dflt_word0_data", 64'(got_d[gb].data), 64'({pv(68, 48, 0), pv(64, 48, 0)}));
            chk("dflt_last_addr", 64'(got_d[$].addr), 64'd127);
        end
        chk("dflt_short", 64'(cap_short_d), 64'd1);
        chk("dflt_done", 64'(done_d - d0), 64'd1);
        chk("dflt_fcnt", 64'(frame_cnt_d), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences camera pixel capture into the dual-port VRAM (32-bit x 6144 words, write port on pclk).
- Detects frame and line boundaries from vsync/href and assembles RGB565 pixels from byte pairs.
- Crops and decimates a window down to 128x96 and packs two pixels per 32-bit word.
- Drives the VRAM write port and provides single-shot or continuous capture control, with busy/done/short-frame status.

Parameters:
OUT_W, 128, output pixels per line (even)
OUT_H, 96, output lines per frame
DEC_SHIFT, 2, decimation = 2^DEC_SHIFT in both axes
X_OFS, 64, first input pixel column of window
Y_OFS, 48, first input line of window
ADDR_W, 13, VRAM word address width

Ports:
pclk  in  1  camera pixel clock; all logic on rising edge
rstb  in  1  asynchronous active-low reset
c_vsync  in  1  camera vsync, active-high pulse at frame start
href  in  1  line valid; bytes valid while high
in_data  in  8  camera byte, sampled on pclk rising edge
cap_mode  in  1  0 single frame, 1 continuous
cap_req  in  1  1-cycle start pulse (already pclk-synchronous)
cap_stop  in  1  level; ends continuous mode after the current frame
wea  out  1  VRAM write strobe
addra  out  ADDR_W  VRAM word address
dina  out  32  {odd_pixel[15:0], even_pixel[15:0]}
cap_busy  out  1  high outside IDLE
cap_done  out  1  1-cycle pulse at end of each captured frame
cap_short  out  1  sticky; frame ended before the last word was written
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset: rstb asynchronous, active-low; clock pclk. All outputs 0, state IDLE, all counters 0, VRAM contents untouched. Reset asserted mid-frame abandons the frame; no partial status is retained.
- Edge detection: vs_d and href_d are registered copies of the inputs.
  - Frame start = vs_d & ~c_vsync.
  - Line end = href_d & ~href.
- State machine:
  - IDLE: cap_req -> WAIT_VS; clear cap_short.
  - WAIT_VS: frame start -> ACTIVE; clear x, y, byte phase and the word address.
  - ACTIVE: last word written -> DONE. A c_vsync rising edge before the last word -> DONE with cap_short=1.
  - DONE (1 cycle): pulse cap_done; frame_cnt+1. Then go to WAIT_VS if cap_mode=1 and cap_stop=0, else IDLE.
  - cap_req while not in IDLE is ignored. Changing cap_mode mid-frame takes effect at DONE.
- Pixel assembly (ACTIVE, href=1):
  - Byte phase toggles each pclk. Phase 0 latches the high byte; phase 1 forms pix={hi, in_data}, then increments input column x.
  - Line end: y+1, x=0, phase=0. An incomplete pixel is discarded.
- Window and decimation:
  - A pixel is kept iff all of the following hold:
    - X_OFS <= x < X_OFS+OUT_W*2^DEC_SHIFT
    - Y_OFS <= y < Y_OFS+OUT_H*2^DEC_SHIFT
    - (x-X_OFS) and (y-Y_OFS) have low DEC_SHIFT bits zero
  - Output column ox=(x-X_OFS)>>DEC_SHIFT; output line oy=(y-Y_OFS)>>DEC_SHIFT.
- Packing:
  - Even ox: pixel held in a 16-bit register.
  - Odd ox: registered write with dina={pix, held}, addra=oy*(OUT_W/2)+ox/2.
  - wea is high exactly one pclk, starting the cycle after the edge that sampled the odd pixel's low byte.
  - addra and dina are stable while wea=1 and hold their last value otherwise.
- Last word = OUT_W*OUT_H/2-1 (6143 with defaults). The wea pulse for it coincides with the transition to DONE; cap_done follows one cycle later.
- Counters sized so that x and y cannot overflow with 1023 pixels/line and 1023 lines. Beyond that they saturate and produce no writes.
- Lines and pixels outside the window produce no writes. Frames in WAIT_VS or IDLE produce no writes.

Test Plan:
- Single frame, 640x480 ramp (pix = x + y*640): cap_req, cap_mode=0 -> exactly 6144 wea pulses at addra 0..6143 in order. Word 0 dina={pix(68,48), pix(64,48)}. cap_done pulse once, frame_cnt=1, cap_busy low afterwards, cap_short=0.
- Short frame: vsync rises after input line 200 -> last addra=(200-48)/4*64+63=2495, cap_short=1, cap_done pulses, return to IDLE.
- Continuous mode, 3 frames then cap_stop raised in frame 3 -> frame_cnt=3, 3 cap_done pulses, IDLE after third, no writes in frame 4.
- cap_req issued mid-frame while IDLE -> no writes until the next vsync falling edge. A second cap_req during ACTIVE is ignored (write count still 6144).
- Line of odd byte count (1281 bytes) -> trailing byte discarded, next line x starts at 0, addresses unchanged vs reference model.
- rstb pulsed low at word 3000 -> wea, cap_busy, frame_cnt = 0 immediately. A new cap_req restarts cleanly from addra 0.
